// File: rtl/ps2_keycode_rx_if.sv
// PS/2 receiver bundle: raw pin inputs plus the keycode history and status pulses.
// The master drives the pins and observes the results; the slave is the receiver.
interface ps2_keycode_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [31:0] keycode;
  logic        byte_valid;
  logic        parity_err;
  logic        frame_err;
  logic        rx_busy;

  modport master (
    output ps2_clk, ps2_data,
    input  keycode, byte_valid, parity_err, frame_err, rx_busy
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keycode, byte_valid, parity_err, frame_err, rx_busy
  );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the pins, decodes 11-bit frames
// and keeps a four-byte keycode history with the newest byte in [7:0].
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic          clk,
  input  logic          reset,
  ps2_keycode_rx_if.slave bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic          filt_q, filt_d, filt_dly_q;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          fall;
  logic          tmo_hit;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   keycode_q, keycode_d;
  logic          bv_q, bv_d, pe_q, pe_d, fe_q, fe_d;

  // Input conditioning: sync to clk, then require FILTER_LEN stable samples
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      clk_meta_q <= bus.ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= bus.ps2_data;
      dat_sync_q <= dat_meta_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      flt_cnt_q  <= flt_cnt_d;
    end
  end

  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (flt_cnt_q == FLT_LAST) filt_d = clk_sync_q;
      else                       flt_cnt_d = flt_cnt_q + FW'(1);
    end
  end

  assign fall    = filt_dly_q & ~filt_q;
  assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TMO_LAST);

  // Frame FSM and keycode history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      keycode_q <= '0;
      bv_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      keycode_q <= keycode_d;
      bv_q      <= bv_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    par_d     = par_q;
    keycode_d = keycode_q;
    bv_d      = 1'b0;
    pe_d      = 1'b0;
    fe_d      = 1'b0;
    if (state_q == S_IDLE || fall) tmo_d = '0;
    else                           tmo_d = tmo_q + TW'(1);

    // A timeout wins over an edge landing in the same cycle
    if (tmo_hit) begin
      fe_d     = 1'b1;
      state_d  = S_IDLE;
      shift_d  = '0;
      bitcnt_d = '0;
      tmo_d    = '0;
    end else if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          if (!dat_sync_q) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end else begin
            fe_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d  = {dat_sync_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_sync_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (^{shift_q, par_q} == 1'b0) begin
            pe_d = 1'b1;
          end else if (!dat_sync_q) begin
            fe_d = 1'b1;
          end else begin
            keycode_d = {keycode_q[23:0], shift_q};
            bv_d      = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.keycode    = keycode_q;
  assign bus.byte_valid = bv_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: drives PS/2 frames on the pins and checks the
// keycode history, status pulses and busy flag against hand-computed values.
module tb_ps2_keycode_rx;

  // PS/2 clock is scaled to 80 clk cycles per bit to keep the run short
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
  int   bv_cyc = 0;
  int   t_fall = 0;
  int   bv0, pe0, fe0;

  ps2_keycode_rx_if bus ();

  ps2_keycode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(20000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse monitor: counts pulses and enforces one-hot, one-cycle-wide pulses
  logic prev_any = 1'b0;
  always @(negedge clk) begin
    logic any;
    any = bus.byte_valid | bus.parity_err | bus.frame_err;
    if (any) begin
      checks++;
      assert (($countones({bus.byte_valid, bus.parity_err, bus.frame_err}) == 1) && !prev_any)
      else begin
        errors++;
        $error("FAIL pulse_shape: observed bv/pe/fe=%b%b%b prev_any=%b, required one pulse, 1 cycle wide",
               bus.byte_valid, bus.parity_err, bus.frame_err, prev_any);
      end
    end
    if (bus.byte_valid) begin bv_cnt++; bv_cyc = cyc; end
    if (bus.parity_err) pe_cnt++;
    if (bus.frame_err)  fe_cnt++;
    prev_any = any;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    bv0 = bv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
  endtask

  task automatic send_bit(input logic b, input int glitch_at);
    bus.ps2_data = b;
    if (glitch_at >= 0) begin
      tick(glitch_at);
      bus.ps2_clk = 1'b0;
      tick(3);
      bus.ps2_clk = 1'b1;
      tick(HALF - glitch_at - 3);
    end else begin
      tick(HALF);
    end
    bus.ps2_clk = 1'b0;
    t_fall = cyc;
    tick(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gl_bit);
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == gl_bit) ? 15 : -1);
    send_bit(p, -1);
    send_bit(s, -1);
    bus.ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    do_reset();
    chk("rst_keycode", bus.keycode, 32'h0);
    chk("rst_bv", {31'b0, bus.byte_valid}, 32'h0);
    chk("rst_pe", {31'b0, bus.parity_err}, 32'h0);
    chk("rst_fe", {31'b0, bus.frame_err}, 32'h0);
    chk("rst_busy", {31'b0, bus.rx_busy}, 32'h0);

    // Single byte 0x1D and its latency from the stop-bit falling edge
    snap();
    send_frame(8'h1D, 1'b1, 1'b1, -1);
    chk("w_bv", bv_cnt - bv0, 1);
    chk("w_err", (pe_cnt - pe0) + (fe_cnt - fe0), 0);
    chk("w_keycode", bus.keycode, 32'h0000001D);
    chk("w_busy", {31'b0, bus.rx_busy}, 32'h0);
    checks++;
    assert ((bv_cyc - t_fall) >= 10 && (bv_cyc - t_fall) <= 12)
    else begin
      errors++;
      $error("FAIL w_latency: observed %0d cycles required 10..12", bv_cyc - t_fall);
    end

    // History of three bytes including a release code
    do_reset();
    snap();
    send_frame(8'h1D, 1'b1, 1'b1, -1);
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    send_frame(8'h1D, 1'b1, 1'b1, -1);
    chk("hist_bv", bv_cnt - bv0, 3);
    chk("hist_keycode", bus.keycode, 32'h001DF01D);

    // Bad parity, then good parity
    snap();
    send_frame(8'h23, 1'b1, 1'b1, -1);
    chk("par_pe", pe_cnt - pe0, 1);
    chk("par_bv", bv_cnt - bv0, 0);
    chk("par_keycode", bus.keycode, 32'h001DF01D);
    send_frame(8'h23, 1'b0, 1'b1, -1);
    chk("par_good_keycode", bus.keycode, 32'h1DF01D23);

    // Truncated frame aborted by timeout
    snap();
    send_bit(1'b0, -1);
    for (int i = 0; i < 5; i++) send_bit(i[0], -1);
    bus.ps2_data = 1'b1;
    tick(19500);
    chk("tmo_busy_before", {31'b0, bus.rx_busy}, 32'h1);
    chk("tmo_fe_early", fe_cnt - fe0, 0);
    for (int i = 0; i < 1000 && fe_cnt == fe0; i++) tick(1);
    tick(2);
    chk("tmo_fe", fe_cnt - fe0, 1);
    chk("tmo_busy_after", {31'b0, bus.rx_busy}, 32'h0);
    chk("tmo_keycode", bus.keycode, 32'h1DF01D23);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    chk("tmo_next_keycode", bus.keycode, 32'hF01D231C);
    chk("tmo_next_err", (pe_cnt - pe0) + (fe_cnt - fe0), 0);

    // Short glitch on ps2_clk during data bit 3
    snap();
    send_frame(8'h42, 1'b1, 1'b1, 3);
    chk("glitch_keycode", bus.keycode, 32'h1D231C42);
    chk("glitch_err", (pe_cnt - pe0) + (fe_cnt - fe0), 0);

    // Bad stop bit
    snap();
    send_frame(8'h4B, 1'b1, 1'b0, -1);
    chk("stop_fe", fe_cnt - fe0, 1);
    chk("stop_bv", bv_cnt - bv0, 0);
    chk("stop_keycode", bus.keycode, 32'h1D231C42);

    // Reset after the 4th data bit of 0xF0; the rest of the frame is all ones
    snap();
    send_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, -1);
    chk("mid_busy", {31'b0, bus.rx_busy}, 32'h1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_keycode", bus.keycode, 32'h0);
    chk("mid_busy_rst", {31'b0, bus.rx_busy}, 32'h0);
    chk("mid_pulses", {29'b0, bus.byte_valid, bus.parity_err, bus.frame_err}, 32'h0);
    for (int i = 0; i < 6; i++) send_bit(1'b1, -1);
    tick(HALF);
    chk("mid_tail_bv", bv_cnt - bv0, 0);
    chk("mid_tail_fe", fe_cnt - fe0, 6);
    chk("mid_tail_busy", {31'b0, bus.rx_busy}, 32'h0);
    send_frame(8'h43, 1'b0, 1'b1, -1);
    chk("mid_next_keycode", bus.keycode, 32'h00000043);
    chk("mid_next_bv", bv_cnt - bv0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
